// File: rtl/mdp3_pkg.sv
// Shared constants and state encoding for the MDP3 UDP header stripper.
package mdp3_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam int unsigned HDR_BYTES      = 42;
    localparam int unsigned HDR_LAST_BEAT  = 5;
    // Payload bytes carried by the beat that holds the end of the headers.
    localparam int unsigned HELD_BYTES     = 8 * (HDR_LAST_BEAT + 1) - HDR_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FIRST,
        ST_PAYLOAD,
        ST_FLUSH,
        ST_DROP
    } state_t;

    // Clears the low-order unused bytes of an end-of-packet beat.
    function automatic logic [63:0] keep_mask(input logic [2:0] empty);
        return 64'hFFFF_FFFF_FFFF_FFFF << {empty, 3'b000};
    endfunction

endpackage

// File: rtl/mdp3_udp_stripper.sv
// Validates Ethernet II / IPv4 / UDP headers of incoming frames, strips them and
// re-aligns the MDP3 payload onto a 64-bit Avalon-ST source; bad frames are dropped and counted.
module mdp3_udp_stripper
    import mdp3_pkg::*;
#(
    parameter logic [15:0] DST_PORT       = 16'd14310,
    parameter bit          PORT_FILTER_EN = 1'b1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [2:0]       in_empty,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic [2:0]       out_empty,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned HW = 8 * HELD_BYTES;

    state_t             r_state;
    logic [2:0]         r_beat;
    logic [HW-1:0]      r_held;
    logic               r_first_pend;
    logic [2:0]         r_empty_save;
    logic               r_out_valid;
    logic [63:0]        r_out_data;
    logic               r_out_sop;
    logic               r_out_eop;
    logic [2:0]         r_out_empty;
    logic [CNT_W-1:0]   r_pkt;
    logic [CNT_W-1:0]   r_drop;

    logic               w_out_free;
    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_tail_short;
    logic               w_hdr_ok;
    logic               w_emit;
    logic [63:0]        w_emit_data;
    logic               w_emit_sop;
    logic               w_emit_eop;
    logic [2:0]         w_emit_empty;

    assign w_out_free   = !r_out_valid || out_ready;
    assign w_in_ready   = !reset && (r_state != ST_FLUSH) && w_out_free;
    assign w_in_fire    = in_valid && w_in_ready;
    assign w_out_fire   = r_out_valid && out_ready;
    // Last beat carries at most the two trailing header bytes' worth of new data.
    assign w_tail_short = (in_empty >= 3'd6);

    always_comb begin
        w_hdr_ok = 1'b1;
        case (r_beat)
            3'd1: w_hdr_ok = (in_data[31:16] == ETHERTYPE_IPV4) && (in_data[15:8] == IPV4_VER_IHL);
            3'd2: w_hdr_ok = (in_data[7:0] == IP_PROTO_UDP);
            3'd4: w_hdr_ok = !PORT_FILTER_EN || (in_data[31:16] == DST_PORT);
            default: w_hdr_ok = 1'b1;
        endcase
    end

    always_comb begin
        w_emit       = 1'b0;
        w_emit_data  = '0;
        w_emit_sop   = 1'b0;
        w_emit_eop   = 1'b0;
        w_emit_empty = '0;
        if (w_in_fire) begin
            case (r_state)
                ST_FIRST: begin
                    if (in_eop && !w_tail_short) begin
                        w_emit       = 1'b1;
                        w_emit_data  = {in_data[HW-1:0], {(64-HW){1'b0}}};
                        w_emit_sop   = 1'b1;
                        w_emit_eop   = 1'b1;
                        w_emit_empty = in_empty + 3'd2;
                    end
                end
                ST_PAYLOAD: begin
                    w_emit      = 1'b1;
                    w_emit_data = {r_held, in_data[63 -: (64-HW)]};
                    w_emit_sop  = r_first_pend;
                    if (in_eop && w_tail_short) begin
                        w_emit_eop   = 1'b1;
                        w_emit_empty = in_empty - 3'd6;
                    end
                end
                default: ;
            endcase
        end else if (r_state == ST_FLUSH && w_out_free) begin
            w_emit       = 1'b1;
            w_emit_data  = {r_held, {(64-HW){1'b0}}};
            w_emit_eop   = 1'b1;
            w_emit_empty = r_empty_save + 3'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_held       <= '0;
            r_first_pend <= 1'b0;
            r_empty_save <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_out_empty  <= '0;
            r_pkt        <= '0;
            r_drop       <= '0;
        end else begin
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_emit_data & keep_mask(w_emit_empty);
                r_out_sop   <= w_emit_sop;
                r_out_eop   <= w_emit_eop;
                r_out_empty <= w_emit_empty;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end

            if (w_out_fire && r_out_eop)
                r_pkt <= r_pkt + CNT_W'(1);

            if (w_in_fire) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!in_sop) begin
                            r_drop <= r_drop + CNT_W'(1);
                            if (!in_eop)
                                r_state <= ST_DROP;
                        end else if (in_eop) begin
                            r_drop <= r_drop + CNT_W'(1);
                        end else begin
                            r_state <= ST_HDR;
                            r_beat  <= 3'd1;
                        end
                    end
                    ST_HDR: begin
                        if (in_eop || !w_hdr_ok) begin
                            r_drop  <= r_drop + CNT_W'(1);
                            r_state <= in_eop ? ST_IDLE : ST_DROP;
                        end else if (r_beat == 3'(HDR_LAST_BEAT - 1)) begin
                            r_state <= ST_FIRST;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
                    ST_FIRST: begin
                        if (in_eop) begin
                            if (w_tail_short)
                                r_drop <= r_drop + CNT_W'(1);
                            r_state <= ST_IDLE;
                        end else begin
                            r_held       <= in_data[HW-1:0];
                            r_first_pend <= 1'b1;
                            r_state      <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_first_pend <= 1'b0;
                        r_held       <= in_data[HW-1:0];
                        if (in_eop) begin
                            r_empty_save <= in_empty;
                            r_state      <= w_tail_short ? ST_IDLE : ST_FLUSH;
                        end
                    end
                    ST_DROP: begin
                        if (in_eop)
                            r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state == ST_FLUSH && w_out_free) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sop    = r_out_sop;
    assign out_eop    = r_out_eop;
    assign out_empty  = r_out_empty;
    assign pkt_count  = r_pkt;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_mdp3_udp_stripper.sv
// Scoreboard bench for mdp3_udp_stripper: builds frames byte by byte, predicts the
// stripped payload beats and counter values, and compares against the source stream.
module tb_mdp3_udp_stripper;

    localparam logic [15:0] DST_PORT = 16'd14310;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic [2:0]  in_empty;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_empty;
    logic [31:0] pkt_count;
    logic [31:0] drop_count;

    beat_t       exp_q[$];
    beat_t       mon_e;
    logic [7:0]  frm[$];
    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;
    int unsigned exp_pkt  = 0;
    int unsigned exp_drop = 0;
    bit          rand_ready = 1'b0;

    always #5 clk = ~clk;

    mdp3_udp_stripper #(
        .DST_PORT       (DST_PORT),
        .PORT_FILTER_EN (1'b1),
        .CNT_W          (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_empty   (in_empty),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_empty  (out_empty),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic make_frame(input int unsigned n, input logic [15:0] etype,
                              input logic [7:0] proto, input logic [15:0] port);
        frm.delete();
        for (int unsigned i = 0; i < n; i++)
            frm.push_back(8'($urandom));
        if (n > 13) begin frm[12] = etype[15:8]; frm[13] = etype[7:0]; end
        if (n > 14) frm[14] = 8'h45;
        if (n > 23) frm[23] = proto;
        if (n > 37) begin frm[36] = port[15:8]; frm[37] = port[7:0]; end
    endtask

    task automatic push_expected(input int unsigned n, input bit hdr_good);
        int unsigned len;
        int unsigned nb;
        beat_t       b;
        if (!hdr_good || n <= 42) begin
            exp_drop++;
            return;
        end
        len = n - 42;
        nb  = (len + 7) / 8;
        for (int unsigned k = 0; k < nb; k++) begin
            b.data = '0;
            for (int unsigned j = 0; j < 8; j++)
                if (42 + 8 * k + j < n)
                    b.data[63 - 8 * j -: 8] = frm[42 + 8 * k + j];
            b.sop   = (k == 0);
            b.eop   = (k == nb - 1);
            b.empty = b.eop ? 3'(8 * nb - len) : 3'd0;
            exp_q.push_back(b);
        end
        exp_pkt++;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic s, input logic e, input logic [2:0] em);
        int unsigned t;
        bit          ok;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_empty = em;
        in_valid = 1'b1;
        t  = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!ok && t > 1000) begin
                check_val("in_ready_timeout", 64'(in_ready), 64'd1);
                ok = 1'b1;
            end
        end
    endtask

    task automatic send_range(input int unsigned n, input int unsigned b0, input int unsigned b1);
        int unsigned nb;
        logic [63:0] d;
        nb = (n + 7) / 8;
        for (int unsigned b = b0; b < b1; b++) begin
            d = '0;
            for (int unsigned j = 0; j < 8; j++)
                if (8 * b + j < n)
                    d[63 - 8 * j -: 8] = frm[8 * b + j];
            send_beat(d, (b == 0), (b == nb - 1), (b == nb - 1) ? 3'(8 * nb - n) : 3'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int unsigned n, input logic [15:0] etype,
                             input logic [7:0] proto, input logic [15:0] port);
        make_frame(n, etype, proto, port);
        push_expected(n, (etype == 16'h0800) && (proto == 8'd17) && (port == DST_PORT));
        send_range(n, 0, (n + 7) / 8);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000)
            check_val({tag, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkt));
        check_val({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drop));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", 64'(out_data), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("out_data", out_data, mon_e.data);
                check_val("out_sop", 64'(out_sop), 64'(mon_e.sop));
                check_val("out_eop", 64'(out_eop), 64'(mon_e.eop));
                check_val("out_empty", 64'(out_empty), 64'(mon_e.empty));
            end
        end
        if (!reset && out_valid && !out_ready)
            check_val("in_ready_backpressure", 64'(in_ready), 64'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", n_checks, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_sop", 64'(out_sop), 64'd0);
        check_val("rst_out_eop", 64'(out_eop), 64'd0);
        check_val("rst_out_data", out_data, 64'd0);
        check_val("rst_out_empty", 64'(out_empty), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_pkt_count", 64'(pkt_count), 64'd0);
        check_val("rst_drop_count", 64'(drop_count), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_frame(50, 16'h0800, 8'd17, DST_PORT);
        wait_drain("len8");
        run_frame(46, 16'h0800, 8'd17, DST_PORT);
        wait_drain("len4");

        // 13-byte payload ends in a flush beat, during which the sink is held off.
        run_frame(55, 16'h0800, 8'd17, DST_PORT);
        @(negedge clk);
        check_val("flush_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("after_flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        wait_drain("len13");

        run_frame(60, 16'h0800, 8'd17, 16'd1234);
        run_frame(60, 16'h86DD, 8'd17, DST_PORT);
        run_frame(60, 16'h0800, 8'd6,  DST_PORT);
        run_frame(70, 16'h0800, 8'd17, DST_PORT);
        wait_drain("bad_hdrs");

        run_frame(42, 16'h0800, 8'd17, DST_PORT);
        run_frame(44, 16'h0800, 8'd17, DST_PORT);
        run_frame(30, 16'h0800, 8'd17, DST_PORT);
        make_frame(40, 16'h0800, 8'd17, DST_PORT);
        exp_drop++;
        send_range(40, 1, 5);
        run_frame(48, 16'h0800, 8'd17, DST_PORT);
        wait_drain("edges");

        rand_ready = 1'b1;
        run_frame(142, 16'h0800, 8'd17, DST_PORT);
        for (int unsigned k = 0; k < 6; k++) begin
            n = $urandom_range(43, 150);
            run_frame(n, 16'h0800, 8'd17, DST_PORT);
        end
        wait_drain("backpressure");
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset lands mid-payload; the rest of that frame arrives without a sop.
        make_frame(106, 16'h0800, 8'd17, DST_PORT);
        send_range(106, 0, 6);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_pkt_count", 64'(pkt_count), 64'd0);
        check_val("midrst_drop_count", 64'(drop_count), 64'd0);
        reset    = 1'b0;
        exp_pkt  = 0;
        exp_drop = 1;
        send_range(106, 6, 14);
        wait_drain("orphan");
        run_frame(64, 16'h0800, 8'd17, DST_PORT);
        wait_drain("post_reset");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
